conv_layer_input_ctrl: RTL and testbench

//  Sequencer for the conv-layer row input buffer. Accepts the image pixel stream over a valid/ready

---
 rtl/conv_layer_input_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_conv_layer_input_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_input_ctrl.sv
// -----------------------------------------------------------------------------
// conv_layer_input_ctrl
//
// Sequencer for the conv-layer row input buffer. It accepts the image pixel
// stream from the upstream feeder and issues buffer commands. A frame runs as
// preload (BUFFER_ROW rows), then repeats {shift, bias, load next row} until
// IMAGE_ROW rows have been consumed.
//
// Handshake: a pixel is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on the FSM state, never on
// in_valid. in_valid may be held high while in_ready is low; nothing is
// consumed on those cycles.
//
// Output timing: every output is a register. current_state/col_index report
// the action taken at the previous edge, so a LOAD command lines up with the
// pixel the datapath registered on that same edge. in_ready and busy follow
// the FSM state directly.
//
// Buffer command encodings (STATE_*):
//   STATE_IDLE = 0, STATE_LOAD = 1, STATE_SHIFT = 2, STATE_BIAS = 3
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous, active-high reset
//   start          1-cycle frame start pulse; ignored unless idle
//   in_valid       upstream pixel valid
//   in_ready       controller accepts a pixel (PRELOAD/LOAD)
//   current_state  buffer command (STATE_*)
//   col_index      column written by the accepted pixel
//   row_index      buffer row selected for readout during SHIFT
//   preload_cycle  rows completed during preload (saturates at BUFFER_ROW-1)
//   win_col        window start column during SHIFT
//   busy           high from accepted start until done
//   done           1-cycle pulse after the last BIAS of the frame
//   stall_cnt      (only with CONV_CTRL_STALL_CNT_EN) count of cycles with
//                  in_ready && !in_valid, saturating, cleared on start/rst
//
// Optional feature macro: CONV_CTRL_STALL_CNT_EN
// -----------------------------------------------------------------------------
module conv_layer_input_ctrl #(
  parameter int BUFFER_ROW       = 3,
  parameter int BUFFER_ROW_WIDTH = 2,
  parameter int BUFFER_COL       = 8,
  parameter int BUFFER_COL_WIDTH = 3,
  parameter int KERNEL_SIZE      = 3,
  parameter int IMAGE_ROW        = 8,
  parameter int IMAGE_ROW_WIDTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [2:0]                  current_state,
  output logic [BUFFER_COL_WIDTH-1:0] col_index,
  output logic [BUFFER_ROW_WIDTH-1:0] row_index,
  output logic [BUFFER_ROW_WIDTH-1:0] preload_cycle,
  output logic [BUFFER_COL_WIDTH-1:0] win_col,
  output logic                        busy,
  output logic                        done
`ifdef CONV_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  // Buffer command encodings
  localparam logic [2:0] STATE_IDLE  = 3'd0;
  localparam logic [2:0] STATE_LOAD  = 3'd1;
  localparam logic [2:0] STATE_SHIFT = 3'd2;
  localparam logic [2:0] STATE_BIAS  = 3'd3;

  // Window positions per row
  localparam int OUT_COL = BUFFER_COL - KERNEL_SIZE + 1;

  // Explicit wrap/limit values for every counter
  localparam logic [BUFFER_COL_WIDTH-1:0] COL_LAST   = BUFFER_COL_WIDTH'(BUFFER_COL - 1);
  localparam logic [BUFFER_COL_WIDTH-1:0] WIN_LAST   = BUFFER_COL_WIDTH'(OUT_COL - 1);
  localparam logic [BUFFER_ROW_WIDTH-1:0] ROW_LAST   = BUFFER_ROW_WIDTH'(BUFFER_ROW - 1);
  localparam logic [IMAGE_ROW_WIDTH-1:0]  PRE_LAST   = IMAGE_ROW_WIDTH'(BUFFER_ROW - 1);
  localparam logic [IMAGE_ROW_WIDTH-1:0]  FRAME_ROWS = IMAGE_ROW_WIDTH'(IMAGE_ROW);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_SHIFT   = 3'd2,
    S_BIAS    = 3'd3,
    S_LOAD    = 3'd4,
    S_DONE    = 3'd5
  } fsm_t;

  fsm_t state, state_d;

  // Internal counters
  logic [BUFFER_COL_WIDTH-1:0] col_cnt, col_cnt_d;     // next column to accept
  logic [BUFFER_ROW_WIDTH-1:0] srow_cnt, srow_cnt_d;   // shift readout row
  logic [BUFFER_COL_WIDTH-1:0] swin_cnt, swin_cnt_d;   // shift window column
  logic [IMAGE_ROW_WIDTH-1:0]  rows_loaded, rows_loaded_d;

  // Next values of the output registers
  logic                        in_ready_d;
  logic [2:0]                  current_state_d;
  logic [BUFFER_COL_WIDTH-1:0] col_index_d;
  logic [BUFFER_ROW_WIDTH-1:0] row_index_d;
  logic [BUFFER_ROW_WIDTH-1:0] preload_cycle_d;
  logic [BUFFER_COL_WIDTH-1:0] win_col_d;
  logic                        busy_d;
  logic                        done_d;

  logic accept;
  logic row_done;

  // in_ready is high exactly in PRELOAD/LOAD, so this is the transfer event
  assign accept   = in_valid && in_ready;
  assign row_done = accept && (col_cnt == COL_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state;
    col_cnt_d       = col_cnt;
    srow_cnt_d      = srow_cnt;
    swin_cnt_d      = swin_cnt;
    rows_loaded_d   = rows_loaded;
    current_state_d = STATE_IDLE;
    col_index_d     = col_index;
    row_index_d     = row_index;
    preload_cycle_d = preload_cycle;
    win_col_d       = win_col;
    done_d          = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d         = S_PRELOAD;
          col_cnt_d       = '0;
          srow_cnt_d      = '0;
          swin_cnt_d      = '0;
          rows_loaded_d   = '0;
          col_index_d     = '0;
          row_index_d     = '0;
          win_col_d       = '0;
          preload_cycle_d = '0;
        end
      end

      S_PRELOAD, S_LOAD: begin
        // Without a transfer the command stays IDLE so the buffer never
        // writes a bubble and col_index holds.
        if (accept) begin
          current_state_d = STATE_LOAD;
          col_index_d     = col_cnt;
          col_cnt_d       = row_done ? '0 : col_cnt + BUFFER_COL_WIDTH'(1);
          if (row_done) begin
            rows_loaded_d = rows_loaded + IMAGE_ROW_WIDTH'(1);
            if (state == S_LOAD) begin
              state_d = S_SHIFT;
            end else if (rows_loaded == PRE_LAST) begin
              // Final preload row: preload_cycle keeps BUFFER_ROW-1
              state_d = S_SHIFT;
            end else begin
              preload_cycle_d = preload_cycle + BUFFER_ROW_WIDTH'(1);
            end
          end
        end
      end

      S_SHIFT: begin
        current_state_d = STATE_SHIFT;
        row_index_d     = srow_cnt;
        win_col_d       = swin_cnt;
        if (srow_cnt == ROW_LAST) begin
          srow_cnt_d = '0;
          if (swin_cnt == WIN_LAST) begin
            swin_cnt_d = '0;
            state_d    = S_BIAS;
          end else begin
            swin_cnt_d = swin_cnt + BUFFER_COL_WIDTH'(1);
          end
        end else begin
          srow_cnt_d = srow_cnt + BUFFER_ROW_WIDTH'(1);
        end
      end

      S_BIAS: begin
        current_state_d = STATE_BIAS;
        if (rows_loaded == FRAME_ROWS) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_PRELOAD) || (state_d == S_LOAD);
    // busy drops on the edge that raises done
    busy_d     = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      col_cnt       <= '0;
      srow_cnt      <= '0;
      swin_cnt      <= '0;
      rows_loaded   <= '0;
      in_ready      <= 1'b0;
      current_state <= STATE_IDLE;
      col_index     <= '0;
      row_index     <= '0;
      preload_cycle <= '0;
      win_col       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      col_cnt       <= col_cnt_d;
      srow_cnt      <= srow_cnt_d;
      swin_cnt      <= swin_cnt_d;
      rows_loaded   <= rows_loaded_d;
      in_ready      <= in_ready_d;
      current_state <= current_state_d;
      col_index     <= col_index_d;
      row_index     <= row_index_d;
      preload_cycle <= preload_cycle_d;
      win_col       <= win_col_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

`ifdef CONV_CTRL_STALL_CNT_EN
  // Upstream starvation counter: cycles the controller waited for a pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      stall_cnt <= '0;
    end else if (in_ready && !in_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_input_ctrl
//
// Bench for conv_layer_input_ctrl. dut_a uses the default geometry
// (8x8 image, 3-row buffer); dut_b uses IMAGE_ROW=3 for the single-pass frame.
// A frame-level model (an expected-event queue built from the row/pass
// arithmetic) is checked against dut_a every cycle; literal totals per frame
// pin the model down. Optional stall counter checked with
// CONV_CTRL_STALL_CNT_EN.
// -----------------------------------------------------------------------------
module tb_conv_layer_input_ctrl;

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_LOAD  = 3'd1;
  localparam logic [2:0] C_SHIFT = 3'd2;
  localparam logic [2:0] C_BIAS  = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic in_valid = 1'b0;

  logic       in_ready_a, busy_a, done_a;
  logic [2:0] cs_a, col_a, win_a;
  logic [1:0] row_a, pre_a;
  logic       in_ready_b, busy_b, done_b;
  logic [2:0] cs_b, col_b, win_b;
  logic [1:0] row_b, pre_b;
`ifdef CONV_CTRL_STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
`endif

  conv_layer_input_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid),
    .in_ready(in_ready_a), .current_state(cs_a), .col_index(col_a),
    .row_index(row_a), .preload_cycle(pre_a), .win_col(win_a),
    .busy(busy_a), .done(done_a)
`ifdef CONV_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_a)
`endif
  );

  conv_layer_input_ctrl #(.IMAGE_ROW(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid),
    .in_ready(in_ready_b), .current_state(cs_b), .col_index(col_b),
    .row_index(row_b), .preload_cycle(pre_b), .win_col(win_b),
    .busy(busy_b), .done(done_b)
`ifdef CONV_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- frame-level model ----------------
  // event: {cmd[11:9], col[8:6], row[5:4], win[3:1], done[0]}
  logic [11:0] exp_q[$];
  logic        m_busy = 0, m_done = 0, m_ready = 0;
  logic [2:0]  m_cmd = 0, m_col = 0, m_win = 0;
  logic [1:0]  m_row = 0, m_pre = 0;
  logic [31:0] m_stall = 0;
  int          m_words = 0;

  function automatic logic [11:0] ev_pack(input logic [2:0] cmd, input logic [2:0] col,
                                          input logic [1:0] row, input logic [2:0] win,
                                          input logic dn);
    return {cmd, col, row, win, dn};
  endfunction

  // 3 preload rows, then (rows-2) passes of 18 shifts + bias, with one
  // 8-word row between passes, then the done pulse.
  task automatic gen_frame(input int rows);
    exp_q.delete();
    for (int i = 0; i < 24; i++) exp_q.push_back(ev_pack(C_LOAD, 3'(i % 8), 2'd0, 3'd0, 1'b0));
    for (int p = 0; p < rows - 2; p++) begin
      for (int i = 0; i < 18; i++) exp_q.push_back(ev_pack(C_SHIFT, 3'd0, 2'(i % 3), 3'(i / 3), 1'b0));
      exp_q.push_back(ev_pack(C_BIAS, 3'd0, 2'd0, 3'd0, 1'b0));
      if (p < rows - 3)
        for (int i = 0; i < 8; i++) exp_q.push_back(ev_pack(C_LOAD, 3'(i), 2'd0, 3'd0, 1'b0));
    end
    exp_q.push_back(ev_pack(C_IDLE, 3'd0, 2'd0, 3'd0, 1'b1));
  endtask

  task automatic model_step();
    logic [11:0] ev;
    if (rst) begin
      exp_q.delete();
      m_busy = 0; m_done = 0; m_ready = 0; m_cmd = C_IDLE;
      m_col = 0; m_row = 0; m_win = 0; m_pre = 0; m_stall = 0; m_words = 0;
      return;
    end
    if (m_ready && !in_valid && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    m_cmd  = C_IDLE;
    m_done = 0;
    if (!m_busy) begin
      if (start_a) begin
        gen_frame(8);
        m_busy = 1; m_col = 0; m_row = 0; m_win = 0; m_pre = 0; m_words = 0; m_stall = 0;
      end
    end else if (exp_q.size() > 0) begin
      ev = exp_q[0];
      // a pending word without in_valid is a bubble: IDLE, everything held
      if (!(ev[11:9] == C_LOAD && !in_valid)) begin
        void'(exp_q.pop_front());
        m_cmd = ev[11:9];
        if (ev[11:9] == C_LOAD) begin
          m_col = ev[8:6];
          m_words++;
          if (m_words <= 24) m_pre = 2'((m_words / 8 > 2) ? 2 : m_words / 8);
        end else if (ev[11:9] == C_SHIFT) begin
          m_row = ev[5:4];
          m_win = ev[3:1];
        end else if (ev[0]) begin
          m_done = 1;
          m_busy = 0;
        end
      end
    end
    m_ready = m_busy && (exp_q.size() > 0) && (exp_q[0][11:9] == C_LOAD);
  endtask

  // ---------------- literal frame counters ----------------
  int a_load, a_col0, a_shift, a_bias, a_done, a_idle_busy;
  int b_load, b_shift, b_bias, b_done, b_load_after_shift;
  logic b_seen_shift;

  task automatic clear_counts();
    a_load = 0; a_col0 = 0; a_shift = 0; a_bias = 0; a_done = 0; a_idle_busy = 0;
    b_load = 0; b_shift = 0; b_bias = 0; b_done = 0; b_load_after_shift = 0;
    b_seen_shift = 0;
  endtask

  // ---------------- scoreboard: model step + compare every cycle ----------------
  always @(posedge clk) begin
    model_step();
    #1;
    check("current_state", 32'(cs_a), 32'(m_cmd));
    check("col_index", 32'(col_a), 32'(m_col));
    check("row_index", 32'(row_a), 32'(m_row));
    check("win_col", 32'(win_a), 32'(m_win));
    check("preload_cycle", 32'(pre_a), 32'(m_pre));
    check("in_ready", 32'(in_ready_a), 32'(m_ready));
    check("busy", 32'(busy_a), 32'(m_busy));
    check("done", 32'(done_a), 32'(m_done));
`ifdef CONV_CTRL_STALL_CNT_EN
    check("stall_cnt", stall_a, m_stall);
`endif
    if (cs_a == C_LOAD) a_load++;
    if (cs_a == C_LOAD && col_a == 3'd0) a_col0++;
    if (cs_a == C_SHIFT) a_shift++;
    if (cs_a == C_BIAS) a_bias++;
    if (done_a) a_done++;
    if (busy_a && cs_a == C_IDLE) a_idle_busy++;
    if (cs_b == C_LOAD) b_load++;
    if (cs_b == C_LOAD && b_seen_shift) b_load_after_shift++;
    if (cs_b == C_SHIFT) begin b_shift++; b_seen_shift = 1; end
    if (cs_b == C_BIAS) b_bias++;
    if (done_b) b_done++;
  end

  // ---------------- driver tasks ----------------
  // Runs one dut_a frame; n counts edges after the start edge. Bubbles drop
  // in_valid on every 3rd preload cycle; start is re-pulsed at p1/p2.
  task automatic run_frame_a(input bit bubble, input int p1, input int p2, output int len);
    int n;
    @(negedge clk); start_a = 1;
    @(negedge clk); start_a = 0;
    n = 0;
    while (!done_a && n < 400) begin
      in_valid = !(bubble && n < 35 && (n % 3) == 2);
      start_a  = (n == p1) || (n == p2);
      @(negedge clk);
      n++;
    end
    start_a  = 0;
    in_valid = 1;
    len = n;
  endtask

  task automatic run_frame_b(output int len);
    int n;
    in_valid = 1;
    @(negedge clk); start_b = 1;
    @(negedge clk); start_b = 0;
    n = 0;
    while (!done_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    len = n;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int len;
    int n;
    clear_counts();
    repeat (3) @(negedge clk);
    rst = 0;
    check("reset_state", 32'(cs_a), 32'(C_IDLE));
    check("reset_busy", 32'(busy_a), 32'd0);

    // 1: reset mid-SHIFT aborts with no done
    clear_counts();
    in_valid = 1;
    @(negedge clk); start_a = 1;
    @(negedge clk); start_a = 0;
    n = 0;
    while (cs_a != C_SHIFT && n < 100) begin @(negedge clk); n++; end
    check("reach_shift", 32'(cs_a), 32'(C_SHIFT));
    repeat (4) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_cs", 32'(cs_a), 32'(C_IDLE));
    check("rst_row", 32'(row_a), 32'd0);
    check("rst_win", 32'(win_a), 32'd0);
    check("rst_pre", 32'(pre_a), 32'd0);
    check("rst_ready", 32'(in_ready_a), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_no_done", 32'(a_done), 32'd0);

    // 2 + 4: full frame, in_valid held high
    clear_counts();
    run_frame_a(1'b0, -1, -1, len);
    check("frame_len", 32'(len), 32'd179);
    check("load_words", 32'(a_load), 32'd64);
    check("row_shift_col0", 32'(a_col0), 32'd8);
    check("shift_cycles", 32'(a_shift), 32'd108);
    check("bias_cycles", 32'(a_bias), 32'd6);
    check("done_count", 32'(a_done), 32'd1);
    check("idle_while_busy", 32'(a_idle_busy), 32'd1);
    check("end_pre", 32'(pre_a), 32'd2);
    repeat (3) @(negedge clk);

    // 3: bubbles every 3rd preload cycle
    clear_counts();
    run_frame_a(1'b1, -1, -1, len);
    check("bubble_frame_len", 32'(len), 32'd190);
    check("bubble_load_words", 32'(a_load), 32'd64);
    check("bubble_col0", 32'(a_col0), 32'd8);
    check("bubble_idle", 32'(a_idle_busy), 32'd12);
`ifdef CONV_CTRL_STALL_CNT_EN
    check("bubble_stall_cnt", stall_a, 32'd11);
`endif
    repeat (3) @(negedge clk);

    // 5: start pulsed during BIAS and mid-frame is ignored
    clear_counts();
    run_frame_a(1'b0, 42, 100, len);
    check("restart_frame_len", 32'(len), 32'd179);
    check("restart_done_count", 32'(a_done), 32'd1);
    repeat (3) @(negedge clk);
    check("restart_idle", 32'(busy_a), 32'd0);

    // 6: IMAGE_ROW == BUFFER_ROW, a single pass
    clear_counts();
    run_frame_b(len);
    check("b_frame_len", 32'(len), 32'd44);
    @(negedge clk);
    check("b_load_words", 32'(b_load), 32'd24);
    check("b_shift_cycles", 32'(b_shift), 32'd18);
    check("b_bias_cycles", 32'(b_bias), 32'd1);
    check("b_done_count", 32'(b_done), 32'd1);
    check("b_no_load_state", 32'(b_load_after_shift), 32'd0);
    check("b_busy_after", 32'(busy_b), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
